// File: rtl/mano_pkg.sv
// Shared opcode, state and instruction-bit definitions for the Mano basic-computer core.
package mano_pkg;

    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_LDA = 3'd2;
    localparam logic [2:0] OP_STA = 3'd3;
    localparam logic [2:0] OP_BUN = 3'd4;
    localparam logic [2:0] OP_BSA = 3'd5;
    localparam logic [2:0] OP_ISZ = 3'd6;
    localparam logic [2:0] OP_REG = 3'd7;

    localparam int RB_CLA = 11;
    localparam int RB_CLE = 10;
    localparam int RB_CMA = 9;
    localparam int RB_CME = 8;
    localparam int RB_CIR = 7;
    localparam int RB_CIL = 6;
    localparam int RB_INC = 5;
    localparam int RB_SPA = 4;
    localparam int RB_SNA = 3;
    localparam int RB_SZA = 2;
    localparam int RB_SZE = 1;
    localparam int RB_HLT = 0;

    localparam int IB_INP = 11;
    localparam int IB_OUT = 10;
    localparam int IB_SKI = 9;
    localparam int IB_SKO = 8;
    localparam int IB_ION = 7;
    localparam int IB_IOF = 6;

    typedef enum logic [3:0] {
        S_INTCHK, S_FETCH0, S_FETCH1, S_DECODE, S_INDIR, S_RD, S_OP, S_WR,
        S_BUN, S_BSA1, S_ISZ_INC, S_REG, S_INT0, S_INT1, S_INT2, S_HALT
    } state_e;

    typedef enum logic [3:0] {
        ALU_NOP, ALU_AND, ALU_ADD, ALU_LDA, ALU_CLA, ALU_CLE, ALU_CMA,
        ALU_CME, ALU_CIR, ALU_CIL, ALU_INC, ALU_INP
    } alu_op_e;

    // First execute state for an opcode once the effective address is in AR.
    function automatic state_e exec_state(input logic [2:0] op);
        case (op)
            OP_AND, OP_ADD, OP_LDA, OP_ISZ: return S_RD;
            OP_STA, OP_BSA:                 return S_WR;
            OP_BUN:                         return S_BUN;
            default:                        return S_REG;
        endcase
    endfunction

endpackage

// File: rtl/mano_alu.sv
// Combinational AC/E datapath: logic, add with carry, complements, rotates through E, INP load.
module mano_alu
    import mano_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int IO_W   = 8
) (
    input  alu_op_e           sel,
    input  logic [DATA_W-1:0] ac,
    input  logic              e,
    input  logic [DATA_W-1:0] dr,
    input  logic [IO_W-1:0]   inpr,
    output logic [DATA_W-1:0] ac_nxt,
    output logic              e_nxt
);

    logic [DATA_W:0] sum;

    assign sum = {1'b0, ac} + {1'b0, dr};

    always_comb begin
        ac_nxt = ac;
        e_nxt  = e;
        case (sel)
            ALU_AND: ac_nxt = ac & dr;
            ALU_ADD: {e_nxt, ac_nxt} = sum;
            ALU_LDA: ac_nxt = dr;
            ALU_CLA: ac_nxt = '0;
            ALU_CLE: e_nxt = 1'b0;
            ALU_CMA: ac_nxt = ~ac;
            ALU_CME: e_nxt = ~e;
            ALU_CIR: begin
                ac_nxt = {e, ac[DATA_W-1:1]};
                e_nxt  = ac[0];
            end
            ALU_CIL: begin
                ac_nxt = {ac[DATA_W-2:0], e};
                e_nxt  = ac[DATA_W-1];
            end
            ALU_INC: ac_nxt = ac + DATA_W'(1);
            ALU_INP: ac_nxt[IO_W-1:0] = inpr;
            default: ;
        endcase
    end

endmodule

// File: rtl/mano_core.sv
// Multi-cycle Mano basic-computer core with stallable memory handshake, one I/O pair and interrupt.
// state    | meaning
// INTCHK   | take interrupt or start fetch        FETCH0/1 | AR<=PC, read IR, PC++
// DECODE   | AR<=addr, pick INDIR or execute      INDIR    | AR<=pointer from memory
// RD/OP    | DR<=M[AR], then AC/E update          WR       | store AC, PC or DR
// BUN/BSA1 | branch, BSA return-address step     ISZ_INC  | DR++
// REG      | register-reference or I/O op         INT0-2   | save PC to M[0], jump to 1
// HALT     | parked until reset
module mano_core
    import mano_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 12,
    parameter int IO_W   = 8
) (
    input  logic              CLK,
    input  logic              RST_N,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    input  logic [IO_W-1:0]   in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [IO_W-1:0]   out_data,
    output logic              out_valid,
    input  logic              out_ack,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] ac,
    output logic              e,
    output logic              ien,
    output logic              halted
);

    state_e            state;
    logic [ADDR_W-1:0] ar, tr;
    logic [DATA_W-1:0] ir, dr;
    logic [IO_W-1:0]   inpr, outr;
    logic              fgi, fgo;

    logic              i_bit;
    logic [2:0]        opc;
    alu_op_e           alu_sel;
    logic [DATA_W-1:0] alu_ac;
    logic              alu_e;
    logic              skip, set_halt, io_inp, io_out, ien_set, ien_clr;

    assign i_bit     = ir[DATA_W-1];
    assign opc       = ir[DATA_W-2 -: 3];
    assign mem_req   = (state == S_FETCH1) || (state == S_INDIR) || (state == S_RD) ||
                       (state == S_WR) || (state == S_INT1);
    assign mem_we    = (state == S_WR) || (state == S_INT1);
    assign mem_addr  = ar;
    assign in_ready  = ~fgi;
    assign out_valid = ~fgo;
    assign out_data  = outr;

    always_comb begin
        mem_wdata = ac;
        if (state == S_INT1)     mem_wdata = DATA_W'(tr);
        else if (opc == OP_BSA)  mem_wdata = DATA_W'(pc);
        else if (opc == OP_ISZ)  mem_wdata = dr;
    end

    // Only the highest set bit of a register-reference or I/O word takes effect.
    always_comb begin
        alu_sel  = ALU_NOP;
        skip     = 1'b0;
        set_halt = 1'b0;
        io_inp   = 1'b0;
        io_out   = 1'b0;
        ien_set  = 1'b0;
        ien_clr  = 1'b0;
        if (state == S_OP) begin
            case (opc)
                OP_AND:  alu_sel = ALU_AND;
                OP_ADD:  alu_sel = ALU_ADD;
                OP_LDA:  alu_sel = ALU_LDA;
                default: ;
            endcase
        end else if (state == S_REG && !i_bit) begin
            if      (ir[RB_CLA]) alu_sel = ALU_CLA;
            else if (ir[RB_CLE]) alu_sel = ALU_CLE;
            else if (ir[RB_CMA]) alu_sel = ALU_CMA;
            else if (ir[RB_CME]) alu_sel = ALU_CME;
            else if (ir[RB_CIR]) alu_sel = ALU_CIR;
            else if (ir[RB_CIL]) alu_sel = ALU_CIL;
            else if (ir[RB_INC]) alu_sel = ALU_INC;
            else if (ir[RB_SPA]) skip = ~ac[DATA_W-1];
            else if (ir[RB_SNA]) skip = ac[DATA_W-1];
            else if (ir[RB_SZA]) skip = (ac == '0);
            else if (ir[RB_SZE]) skip = ~e;
            else if (ir[RB_HLT]) set_halt = 1'b1;
        end else if (state == S_REG) begin
            if (ir[IB_INP]) begin
                alu_sel = ALU_INP;
                io_inp  = 1'b1;
            end
            else if (ir[IB_OUT]) io_out  = 1'b1;
            else if (ir[IB_SKI]) skip    = fgi;
            else if (ir[IB_SKO]) skip    = fgo;
            else if (ir[IB_ION]) ien_set = 1'b1;
            else if (ir[IB_IOF]) ien_clr = 1'b1;
        end
    end

    mano_alu #(.DATA_W(DATA_W), .IO_W(IO_W)) u_alu (
        .sel    (alu_sel),
        .ac     (ac),
        .e      (e),
        .dr     (dr),
        .inpr   (inpr),
        .ac_nxt (alu_ac),
        .e_nxt  (alu_e)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state  <= S_INTCHK;
            pc     <= '0;
            ar     <= '0;
            ir     <= '0;
            dr     <= '0;
            ac     <= '0;
            tr     <= '0;
            inpr   <= '0;
            outr   <= '0;
            e      <= 1'b0;
            ien    <= 1'b0;
            fgi    <= 1'b0;
            fgo    <= 1'b1;
            halted <= 1'b0;
        end else begin
            if (in_valid && !fgi) begin
                inpr <= in_data;
                fgi  <= 1'b1;
            end
            if (out_ack && !fgo) fgo <= 1'b1;
            case (state)
                S_INTCHK: state <= (ien && (fgi || fgo)) ? S_INT0 : S_FETCH0;
                S_FETCH0: begin
                    ar    <= pc;
                    state <= S_FETCH1;
                end
                S_FETCH1: if (mem_ready) begin
                    ir    <= mem_rdata;
                    pc    <= pc + ADDR_W'(1);
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    ar    <= ir[ADDR_W-1:0];
                    state <= (i_bit && opc != OP_REG) ? S_INDIR : exec_state(opc);
                end
                S_INDIR: if (mem_ready) begin
                    ar    <= mem_rdata[ADDR_W-1:0];
                    state <= exec_state(opc);
                end
                S_RD: if (mem_ready) begin
                    dr    <= mem_rdata;
                    state <= (opc == OP_ISZ) ? S_ISZ_INC : S_OP;
                end
                S_OP: begin
                    ac    <= alu_ac;
                    e     <= alu_e;
                    state <= S_INTCHK;
                end
                S_ISZ_INC: begin
                    dr    <= dr + DATA_W'(1);
                    state <= S_WR;
                end
                S_WR: if (mem_ready) begin
                    if (opc == OP_ISZ && dr == '0) pc <= pc + ADDR_W'(1);
                    state <= (opc == OP_BSA) ? S_BSA1 : S_INTCHK;
                end
                S_BUN: begin
                    pc    <= ar;
                    state <= S_INTCHK;
                end
                S_BSA1: begin
                    ar    <= ar + ADDR_W'(1);
                    pc    <= ar + ADDR_W'(1);
                    state <= S_INTCHK;
                end
                S_REG: begin
                    ac <= alu_ac;
                    e  <= alu_e;
                    if (skip)    pc  <= pc + ADDR_W'(1);
                    if (io_inp)  fgi <= 1'b0;
                    if (io_out) begin
                        outr <= ac[IO_W-1:0];
                        fgo  <= 1'b0;
                    end
                    if (ien_set) ien <= 1'b1;
                    if (ien_clr) ien <= 1'b0;
                    if (set_halt) halted <= 1'b1;
                    state <= set_halt ? S_HALT : S_INTCHK;
                end
                S_INT0: begin
                    ar    <= '0;
                    tr    <= pc;
                    state <= S_INT1;
                end
                S_INT1: if (mem_ready) begin
                    pc    <= '0;
                    state <= S_INT2;
                end
                S_INT2: begin
                    pc    <= ADDR_W'(1);
                    ien   <= 1'b0;
                    state <= S_INTCHK;
                end
                S_HALT: state <= S_HALT;
                default: state <= S_INTCHK;
            endcase
        end
    end

endmodule
